// File: rtl/mux_display_clock_if.sv
// Bus between the board-side control/display pins and the display clock core.
// Controls come in from the (already debounced) buttons; the display pins and
// the seconds tick go out.
interface mux_display_clock_if #(
  parameter int NUM_DIGITS = 4
);
  logic                  run;
  logic                  clear;
  logic                  inc_min;
  logic                  inc_hr;
  logic [NUM_DIGITS-1:0] AN;
  logic [6:0]            C;
  logic                  DP;
  logic                  tick;

  modport master (
    output run, clear, inc_min, inc_hr,
    input  AN, C, DP, tick
  );

  modport slave (
    input  run, clear, inc_min, inc_hr,
    output AN, C, DP, tick
  );
endinterface

// File: rtl/mux_display_clock.sv
// Multiplexed seven-segment clock: MM:SS (4 digits) or HH:MM:SS (6 digits).
// Time is held as BCD digit pairs. A prescaler derives the one-second tick,
// and a scan counter walks the active-low anodes across the digits.
`timescale 1ns/1ps
module mux_display_clock #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 100000000,
  parameter int SCAN_DIV   = 100000
) (
  input  logic               clock,
  input  logic               reset,
  mux_display_clock_if.slave bus
);

  generate
    if (NUM_DIGITS != 4 && NUM_DIGITS != 6) begin : g_bad_digits
      $error("mux_display_clock: NUM_DIGITS must be 4 or 6");
    end
    if (TICK_DIV < 2) begin : g_bad_tick
      $error("mux_display_clock: TICK_DIV must be at least 2");
    end
    if (SCAN_DIV < 1) begin : g_bad_scan
      $error("mux_display_clock: SCAN_DIV must be at least 1");
    end
  endgenerate

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIGITS - 1);
  localparam bit            HAS_HR     = (NUM_DIGITS == 6);
  localparam logic [NUM_DIGITS-1:0] ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  // BCD pair increment that wraps to 00 after 'last' (59 or 23)
  function automatic logic [7:0] bcd_inc(input logic [7:0] pair, input logic [7:0] last);
    logic [7:0] res;
    if (pair == last)
      res = 8'h00;
    else if (pair[3:0] == 4'd9)
      res = {pair[7:4] + 4'd1, 4'd0};
    else
      res = {pair[7:4], pair[3:0] + 4'd1};
    return res;
  endfunction

  // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 is blank
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [PW-1:0] presc;
  logic [SW-1:0] scan;
  logic [2:0]    idx;
  logic [7:0]    sec_bcd, min_bcd, hr_bcd;

  logic          tick_int, sec_wrap, hr_carry;
  logic [7:0]    sec_next, min_step, min_next, hr_step, hr_next;
  logic [3:0]    digit;

  // Next-time arithmetic: seconds carry first, then the manual minute step;
  // a minute wrap from either step gives at most one hour carry
  always_comb begin
    tick_int = bus.run && !bus.clear && (presc == PRESC_LAST);
    sec_wrap = tick_int && (sec_bcd == 8'h59);
    sec_next = tick_int ? bcd_inc(sec_bcd, 8'h59) : sec_bcd;
    min_step = sec_wrap ? bcd_inc(min_bcd, 8'h59) : min_bcd;
    min_next = bus.inc_min ? bcd_inc(min_step, 8'h59) : min_step;
    hr_carry = sec_wrap && ((min_bcd == 8'h59) || (bus.inc_min && min_step == 8'h59));
    hr_step  = (HAS_HR && hr_carry) ? bcd_inc(hr_bcd, 8'h23) : hr_bcd;
    hr_next  = (HAS_HR && bus.inc_hr) ? bcd_inc(hr_step, 8'h23) : hr_step;
  end

  // Prescaler, timekeeping and the registered tick; clear beats everything
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc    <= '0;
      sec_bcd  <= 8'h00;
      min_bcd  <= 8'h00;
      hr_bcd   <= 8'h00;
      bus.tick <= 1'b0;
    end else if (bus.clear) begin
      presc    <= '0;
      sec_bcd  <= 8'h00;
      min_bcd  <= 8'h00;
      hr_bcd   <= 8'h00;
      bus.tick <= 1'b0;
    end else begin
      if (bus.run)
        presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
      sec_bcd  <= sec_next;
      min_bcd  <= min_next;
      hr_bcd   <= hr_next;
      bus.tick <= tick_int;
    end
  end

  // Scan timer: free-running, advances the digit index on each wrap
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan <= '0;
      idx  <= 3'd0;
    end else if (scan == SCAN_LAST) begin
      scan <= '0;
      idx  <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    end else begin
      scan <= scan + 1'b1;
    end
  end

  // Digit selected by the current scan index
  always_comb begin
    case (idx)
      3'd0:    digit = sec_bcd[3:0];
      3'd1:    digit = sec_bcd[7:4];
      3'd2:    digit = min_bcd[3:0];
      3'd3:    digit = min_bcd[7:4];
      3'd4:    digit = hr_bcd[3:0];
      3'd5:    digit = hr_bcd[7:4];
      default: digit = 4'hF;
    endcase
  end

  // Anodes, cathodes and decimal point registered together so they never skew
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.AN <= '1;
      bus.C  <= 7'b1111111;
      bus.DP <= 1'b1;
    end else begin
      bus.AN <= ~(ONE << idx);
      bus.C  <= seg7(digit);
      bus.DP <= ~((idx == 3'd2) || (idx == 3'd4));
    end
  end

endmodule

// File: tb/tb_mux_display_clock.sv
// Bench for mux_display_clock: a 4-digit and a 6-digit instance share the
// same stimulus and are compared every cycle against an integer time model.
`timescale 1ns/1ps
module tb_mux_display_clock;
  localparam int TD = 4;
  localparam int SD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run, clear, inc_min, inc_hr;
  bit   chk_en = 1'b0;

  always #1 clk = ~clk;

  mux_display_clock_if #(.NUM_DIGITS(4)) b4();
  mux_display_clock_if #(.NUM_DIGITS(6)) b6();

  assign b4.run = run;   assign b6.run = run;
  assign b4.clear = clear; assign b6.clear = clear;
  assign b4.inc_min = inc_min; assign b6.inc_min = inc_min;
  assign b4.inc_hr = inc_hr; assign b6.inc_hr = inc_hr;

  mux_display_clock #(.NUM_DIGITS(4), .TICK_DIV(TD), .SCAN_DIV(SD)) dut4 (
    .clock(clk), .reset(rst_n), .bus(b4.slave));
  mux_display_clock #(.NUM_DIGITS(6), .TICK_DIV(TD), .SCAN_DIV(SD)) dut6 (
    .clock(clk), .reset(rst_n), .bus(b6.slave));

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model (index 0: 4 digits, 1: 6 digits)
  int m_psc[2], m_sec[2], m_min[2], m_hr[2], m_scn[2], m_idx[2];
  int e_an[2], e_c[2], e_dp[2], e_tick[2];

  function automatic int ndig(input int d);
    return (d == 0) ? 4 : 6;
  endfunction

  function automatic int seg(input int v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_psc[d] = 0; m_sec[d] = 0; m_min[d] = 0; m_hr[d] = 0;
      m_scn[d] = 0; m_idx[d] = 0;
      e_an[d] = (1 << ndig(d)) - 1; e_c[d] = 7'h7f; e_dp[d] = 1; e_tick[d] = 0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int n, v;
      bit tk, sc, hc;
      n  = ndig(d);
      tk = run && !clear && (m_psc[d] == TD - 1);
      case (m_idx[d])
        0: v = m_sec[d] % 10;
        1: v = m_sec[d] / 10;
        2: v = m_min[d] % 10;
        3: v = m_min[d] / 10;
        4: v = m_hr[d] % 10;
        default: v = m_hr[d] / 10;
      endcase
      e_an[d]   = ((1 << n) - 1) ^ (1 << m_idx[d]);
      e_c[d]    = seg(v);
      e_dp[d]   = (m_idx[d] == 2 || m_idx[d] == 4) ? 0 : 1;
      e_tick[d] = tk;
      if (clear) begin
        m_psc[d] = 0; m_sec[d] = 0; m_min[d] = 0; m_hr[d] = 0;
      end else begin
        sc = 0; hc = 0;
        if (run) m_psc[d] = (m_psc[d] + 1) % TD;
        if (tk) begin
          m_sec[d]++;
          if (m_sec[d] == 60) begin m_sec[d] = 0; sc = 1; end
        end
        if (sc) begin
          m_min[d]++;
          if (m_min[d] == 60) begin m_min[d] = 0; hc = 1; end
        end
        if (inc_min) begin
          m_min[d]++;
          if (m_min[d] == 60) begin m_min[d] = 0; if (sc) hc = 1; end
        end
        if (n == 6) m_hr[d] = (m_hr[d] + int'(hc) + int'(inc_hr)) % 24;
      end
      m_scn[d]++;
      if (m_scn[d] == SD) begin m_scn[d] = 0; m_idx[d] = (m_idx[d] + 1) % n; end
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) model_edge();
    else model_reset();
  end

  always @(negedge rst_n) model_reset();

  // ---------------- per-cycle comparison on the inactive edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("an4", int'(b4.AN), e_an[0]);
      check("c4", int'(b4.C), e_c[0]);
      check("dp4", int'(b4.DP), e_dp[0]);
      check("tick4", int'(b4.tick), e_tick[0]);
      check("an6", int'(b6.AN), e_an[1]);
      check("c6", int'(b6.C), e_c[1]);
      check("dp6", int'(b6.DP), e_dp[1]);
      check("tick6", int'(b6.tick), e_tick[1]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #0.5;
  endtask

  task automatic pulse_min();
    inc_min = 1'b1; cyc(); inc_min = 1'b0; cyc();
  endtask

  task automatic pulse_hr();
    inc_hr = 1'b1; cyc(); inc_hr = 1'b0; cyc();
  endtask

  initial begin
    int ticks_seen, n, frozen_sec;
    run = 1'b0; clear = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
    model_reset();
    repeat (3) cyc();

    // Reset state
    check("rst_an4", int'(b4.AN), 4'hf);
    check("rst_an6", int'(b6.AN), 6'h3f);
    check("rst_c6", int'(b6.C), 7'h7f);
    check("rst_dp6", int'(b6.DP), 1);
    check("rst_tick4", int'(b4.tick), 0);

    // Count from reset: four ticks, then digit 0 shows '4'
    chk_en = 1'b1;
    run = 1'b1;
    rst_n = 1'b1;
    repeat (17) cyc();
    check("t1_model_sec", m_sec[0], 4);
    check("t1_model_c", e_c[0], 7'b0011001);
    check("t1_an4", int'(b4.AN), 4'b1110);
    check("t1_c4", int'(b4.C), 7'b0011001);
    cyc();
    check("t1_an4_hold", int'(b4.AN), 4'b1110);
    cyc();
    check("t1_an4_next", int'(b4.AN), 4'b1101);

    // Set 23:59 with time frozen, then 59 ticks, then wrap everything
    clear = 1'b1; run = 1'b0; cyc(); clear = 1'b0;
    repeat (23) pulse_hr();
    repeat (59) pulse_min();
    run = 1'b1;
    repeat (59 * TD) cyc();
    check("t3_model_sec", m_sec[1], 59);
    check("t3_model_min", m_min[1], 59);
    check("t3_model_hr", m_hr[1], 23);
    repeat (TD) cyc();
    check("t3_model_wrap6", m_hr[1] * 3600 + m_min[1] * 60 + m_sec[1], 0);
    check("t2_model_wrap4", m_min[0] * 60 + m_sec[0], 0);

    // Manual hour wrap leaves minutes and seconds alone
    run = 1'b0;
    repeat (2) cyc();
    frozen_sec = m_sec[1];
    repeat (23) pulse_hr();
    check("t3_model_hr23", m_hr[1], 23);
    pulse_hr();
    check("t3_model_hr00", m_hr[1], 0);
    check("t3_model_sec_kept", m_sec[1], frozen_sec);

    // Pause mid-count, then resume with the remaining prescaler count
    clear = 1'b1; run = 1'b1; cyc(); clear = 1'b0;
    cyc(); cyc();
    run = 1'b0;
    ticks_seen = 0;
    repeat (20) begin
      cyc();
      if (b4.tick || b6.tick) ticks_seen++;
    end
    check("t4_pause_ticks", ticks_seen, 0);
    check("t4_pause_sec", m_sec[1], 0);
    run = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!b6.tick && n < 10);
    check("t4_resume_latency", n, 2);

    // inc_min together with a seconds carry at minute 58
    clear = 1'b1; run = 1'b0; cyc(); clear = 1'b0;
    repeat (58) pulse_min();
    run = 1'b1;
    repeat (60 * TD - 1) cyc();
    inc_min = 1'b1; cyc(); inc_min = 1'b0;
    check("t5_model_min6", m_min[1], 0);
    check("t5_model_hr6", m_hr[1], 1);
    check("t5_model_min4", m_min[0], 0);
    check("t5_tick6", int'(b6.tick), 1);

    // clear in the tick cycle suppresses the tick
    repeat (TD - 1) cyc();
    clear = 1'b1; cyc(); clear = 1'b0;
    check("t5_clr_tick6", int'(b6.tick), 0);
    check("t5_clr_model_tick", e_tick[1], 0);

    // Randomised operation
    repeat (400) begin
      run     = ($urandom_range(0, 7) != 0);
      clear   = ($urandom_range(0, 63) == 0);
      inc_min = ($urandom_range(0, 15) == 0);
      inc_hr  = ($urandom_range(0, 15) == 0);
      cyc();
    end
    clear = 1'b0; inc_min = 1'b0; inc_hr = 1'b0; run = 1'b1;
    repeat (7) cyc();

    // Asynchronous reset between edges
    rst_n = 1'b0;
    #0.2;
    check("t6_an4", int'(b4.AN), 4'hf);
    check("t6_an6", int'(b6.AN), 6'h3f);
    check("t6_c4", int'(b4.C), 7'h7f);
    check("t6_dp6", int'(b6.DP), 1);
    check("t6_tick6", int'(b6.tick), 0);
    cyc();
    rst_n = 1'b1;
    repeat (17) cyc();
    check("t6_restart_an4", int'(b4.AN), 4'b1110);
    check("t6_restart_c4", int'(b4.C), 7'b0011001);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
